// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron_mac neuron: FSM state encoding,
// default Q8.24 format constants and the accumulator-width helper.
package perceptron_pkg;

  // FSM state encoding, kept as plain constants for legacy tooling
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_ACT  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Default geometry of the neuron
  localparam int DWIDTH_DEF = 32;
  localparam int FRAC_DEF   = 24;
  localparam int NIN_DEF    = 4;

  // Q-format landmarks at the default width/format
  localparam logic [DWIDTH_DEF-1:0] ONE_Q = DWIDTH_DEF'(1) << FRAC_DEF;
  localparam logic [DWIDTH_DEF-1:0] MAX_Q = {1'b0, {(DWIDTH_DEF-1){1'b1}}};
  localparam logic [DWIDTH_DEF-1:0] MIN_Q = {1'b1, {(DWIDTH_DEF-1){1'b0}}};

  // Accumulator width: room for NIN full-scale products plus the bias
  // without ever wrapping internally.
  function automatic int acc_width(input int dwidth, input int nin);
    return dwidth + $clog2(nin) + 1;
  endfunction

  // Index counter width; a single-input neuron still needs one bit.
  function automatic int idx_width(input int nin);
    return (nin > 1) ? $clog2(nin) : 1;
  endfunction

endpackage

// File: rtl/fxp_resolve.sv
// fxp_resolve: narrows the wide accumulator to the output data width.
// Build option PERCEPTRON_MAC_SAT_EN selects clamping (with a flag) over
// plain truncation to the low bits.
module fxp_resolve
  import perceptron_pkg::*;
#(
  parameter int IN_W  = 35,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  a,
  output logic [OUT_W-1:0] y,
  output logic             sat
);

`ifdef PERCEPTRON_MAC_SAT_EN
  // All bits from the output sign bit upward must agree for the value to fit
  logic [IN_W-OUT_W:0] head;
  logic                fits;

  assign head = a[IN_W-1:OUT_W-1];
  assign fits = (&head) | ~(|head);

  // Clamp to the most positive / most negative code when the value does not fit
  always_comb begin
    y   = a[OUT_W-1:0];
    sat = 1'b0;
    if (!fits) begin
      sat = 1'b1;
      y   = a[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  // Wrap mode discards the high accumulator bits on purpose
  logic unused_high;

  assign unused_high = ^a[IN_W-1:OUT_W];
  assign y           = a[OUT_W-1:0];
  assign sat         = 1'b0;
`endif

endmodule

// File: rtl/sigmoid_unit.sv
// sigmoid_unit: combinational piecewise-linear sigmoid in the neuron's
// Q format. Segments on |x|: >=5 -> 1, [2.375,5) -> |x|/32+0.84375,
// [1,2.375) -> |x|/8+0.625, [0,1) -> |x|/4+0.5; negative x gives 1-f(|x|).
module sigmoid_unit
  import perceptron_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int FRAC   = 24
) (
  input  logic [DWIDTH-1:0] a,
  output logic [DWIDTH-1:0] y
);

  localparam logic [DWIDTH:0] ONE   = (DWIDTH+1)'(1)  << FRAC;
  localparam logic [DWIDTH:0] X5    = (DWIDTH+1)'(5)  << FRAC;
  localparam logic [DWIDTH:0] X2375 = (DWIDTH+1)'(19) << (FRAC-3);
  localparam logic [DWIDTH:0] C1    = (DWIDTH+1)'(1)  << (FRAC-1);
  localparam logic [DWIDTH:0] C2    = (DWIDTH+1)'(5)  << (FRAC-3);
  localparam logic [DWIDTH:0] C3    = (DWIDTH+1)'(27) << (FRAC-5);

  logic            neg;
  logic [DWIDTH:0] a_ext;
  logic [DWIDTH:0] mag;
  logic [DWIDTH:0] pos_y;
  logic [DWIDTH:0] y_full;
  logic            unused_top;

  // One extra bit lets the magnitude of the most negative code be represented
  assign neg   = a[DWIDTH-1];
  assign a_ext = {a[DWIDTH-1], a};
  assign mag   = neg ? (~a_ext + (DWIDTH+1)'(1)) : a_ext;

  // Evaluate the positive half of the curve on the magnitude
  always_comb begin
    pos_y = ONE;
    if (mag >= X5) begin
      pos_y = ONE;
    end else if (mag >= X2375) begin
      pos_y = (mag >> 5) + C3;
    end else if (mag >= ONE) begin
      pos_y = (mag >> 3) + C2;
    end else begin
      pos_y = (mag >> 2) + C1;
    end
  end

  // Mirror around 0.5 for negative inputs; the result always lies in [0,1]
  assign y_full     = neg ? (ONE - pos_y) : pos_y;
  assign y          = y_full[DWIDTH-1:0];
  assign unused_top = y_full[DWIDTH];

endmodule

// File: rtl/perceptron_mac.sv
// perceptron_mac: NIN-input fixed-point neuron, y = act(sum x[i]*w[i] + bias),
// using one shared multiplier and one accumulator (one product per clock).
// Valid/ready on both sides; act_sel picks sigmoid (0) or linear (1).
// Build option PERCEPTRON_MAC_SAT_EN enables saturation of the final result
// (see fxp_resolve); without it the result wraps and sat_flag stays 0.
module perceptron_mac
  import perceptron_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int NIN    = NIN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NIN*DWIDTH-1:0] x_flat,
  input  logic [NIN*DWIDTH-1:0] w_flat,
  input  logic [DWIDTH-1:0]     bias,
  input  logic                  act_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DWIDTH-1:0]     out,
  output logic                  sat_flag
);

  localparam int ACC_W = acc_width(DWIDTH, NIN);
  localparam int IDX_W = idx_width(NIN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIN - 1);

  logic [1:0]              state;
  logic [IDX_W-1:0]        idx;
  logic [ACC_W-1:0]        acc;
  logic [DWIDTH-1:0]       x_reg [NIN];
  logic [DWIDTH-1:0]       w_reg [NIN];
  logic                    act_reg;

  logic [DWIDTH-1:0]       x_sel;
  logic [DWIDTH-1:0]       w_sel;
  logic signed [2*DWIDTH-1:0] prod;
  logic [DWIDTH-1:0]       prod_t;
  logic                    unused_prod;

  logic [DWIDTH-1:0]       resolved;
  logic                    res_sat;
  logic [DWIDTH-1:0]       sig_y;

  // Only an idle neuron takes a new operand set; reset parks the FSM in IDLE
  assign in_ready = (state == ST_IDLE);

  // Shared multiplier: full-width signed product, then an arithmetic shift by
  // FRAC (rounding toward -inf) and keep the low DWIDTH bits.
  assign x_sel  = x_reg[idx];
  assign w_sel  = w_reg[idx];
  assign prod   = $signed({{DWIDTH{x_sel[DWIDTH-1]}}, x_sel}) *
                  $signed({{DWIDTH{w_sel[DWIDTH-1]}}, w_sel});
  assign prod_t = prod[FRAC +: DWIDTH];
  assign unused_prod = ^{prod[2*DWIDTH-1:FRAC+DWIDTH], prod[FRAC-1:0]};

  fxp_resolve #(
    .IN_W  (ACC_W),
    .OUT_W (DWIDTH)
  ) u_resolve (
    .a   (acc),
    .y   (resolved),
    .sat (res_sat)
  );

  sigmoid_unit #(
    .DWIDTH (DWIDTH),
    .FRAC   (FRAC)
  ) u_sigmoid (
    .a (resolved),
    .y (sig_y)
  );

  // Transaction FSM: capture operands, accumulate one product per cycle,
  // register the activated result and hold it until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      acc       <= '0;
      act_reg   <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      for (int i = 0; i < NIN; i++) begin
        x_reg[i] <= '0;
        w_reg[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NIN; i++) begin
              x_reg[i] <= x_flat[i*DWIDTH +: DWIDTH];
              w_reg[i] <= w_flat[i*DWIDTH +: DWIDTH];
            end
            act_reg <= act_sel;
            acc     <= {{(ACC_W-DWIDTH){bias[DWIDTH-1]}}, bias};
            idx     <= '0;
            state   <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc + {{(ACC_W-DWIDTH){prod_t[DWIDTH-1]}}, prod_t};
          idx <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            state <= ST_ACT;
          end
        end
        ST_ACT: begin
          out       <= act_reg ? resolved : sig_y;
          sat_flag  <= res_sat;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_mac.sv
// tb_perceptron_mac: directed vector table for perceptron_mac (NIN=4, Q8.24)
// plus hand-written backpressure and mid-transaction reset sequences.
// Expected values follow the PERCEPTRON_MAC_SAT_EN build option.
module tb_perceptron_mac;
  import perceptron_pkg::*;

  localparam int DW  = 32;
  localparam int NI  = 4;
  localparam int NV  = 13;

  typedef struct {
    logic [NI*DW-1:0] x;
    logic [NI*DW-1:0] w;
    logic [DW-1:0]    b;
    logic             act;
    logic [DW-1:0]    exp_out;
    logic             exp_sat;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [NI*DW-1:0] x_flat;
  logic [NI*DW-1:0] w_flat;
  logic [DW-1:0]    bias;
  logic             act_sel;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out;
  logic             sat_flag;

  int errors;
  int checks;
  vec_t vecs [NV];

  perceptron_mac #(
    .DWIDTH (DW),
    .FRAC   (24),
    .NIN    (NI)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_flat    (x_flat),
    .w_flat    (w_flat),
    .bias      (bias),
    .act_sel   (act_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .sat_flag  (sat_flag)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NI*DW-1:0] rep4(input logic [DW-1:0] v);
    return {v, v, v, v};
  endfunction

  function automatic vec_t mk(input logic [NI*DW-1:0] x, input logic [NI*DW-1:0] w,
                              input logic [DW-1:0] b, input logic act,
                              input logic [DW-1:0] eo, input logic es);
    vec_t v;
    v.x = x; v.w = w; v.b = b; v.act = act; v.exp_out = eo; v.exp_sat = es;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand set, scramble inputs after accept, and wait (bounded)
  // for out_valid; lat counts rising edges after the accept edge.
  task automatic apply_stimulus(input vec_t v, output int lat);
    int wait_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    x_flat   = v.x;
    w_flat   = v.w;
    bias     = v.b;
    act_sel  = v.act;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x_flat   = '1;
    w_flat   = '1;
    bias     = 32'h1234_5678;
    act_sel  = ~v.act;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    logic [DW-1:0] held;
    int lat;

    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_flat    = '0;
    w_flat    = '0;
    bias      = '0;
    act_sel   = 1'b0;

    vecs[0]  = mk(rep4(ONE_Q), rep4(32'h0080_0000), 32'h0, 1'b1, 32'h0200_0000, 1'b0);
    vecs[1]  = mk(rep4(32'hFF00_0000), rep4(ONE_Q), ONE_Q, 1'b1, 32'hFD00_0000, 1'b0);
    vecs[2]  = mk(rep4(ONE_Q), rep4(32'h0080_0000), 32'h0, 1'b0, 32'h00E0_0000, 1'b0);
    vecs[3]  = mk(rep4(32'hFF00_0000), rep4(32'h0080_0000), 32'h0, 1'b0, 32'h0020_0000, 1'b0);
    vecs[4]  = mk(rep4(ONE_Q), rep4(32'h0020_0000), 32'h0, 1'b0, 32'h00A0_0000, 1'b0);
    vecs[5]  = mk(rep4(ONE_Q), rep4(32'h0280_0000), 32'h0, 1'b0, ONE_Q, 1'b0);
    vecs[6]  = mk({32'h0400_0000, 32'h0300_0000, 32'h0200_0000, 32'h0100_0000},
                  {32'h0080_0000, 32'h0200_0000, 32'hFF00_0000, 32'h0100_0000},
                  32'h0080_0000, 1'b1, 32'h0780_0000, 1'b0);
    vecs[7]  = mk(rep4(32'hFFFF_FFFF), rep4(32'h0080_0000), 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
`ifdef PERCEPTRON_MAC_SAT_EN
    vecs[8]  = mk(rep4(32'h6400_0000), rep4(ONE_Q), 32'h0, 1'b1, MAX_Q, 1'b1);
    vecs[9]  = mk(rep4(32'h9C00_0000), rep4(ONE_Q), 32'h0, 1'b1, MIN_Q, 1'b1);
    vecs[12] = mk(rep4(32'h6400_0000), rep4(ONE_Q), 32'h0, 1'b0, ONE_Q, 1'b1);
`else
    vecs[8]  = mk(rep4(32'h6400_0000), rep4(ONE_Q), 32'h0, 1'b1, 32'h9000_0000, 1'b0);
    vecs[9]  = mk(rep4(32'h9C00_0000), rep4(ONE_Q), 32'h0, 1'b1, 32'h7000_0000, 1'b0);
    vecs[12] = mk(rep4(32'h6400_0000), rep4(ONE_Q), 32'h0, 1'b0, 32'h0000_0000, 1'b0);
`endif
    vecs[10] = mk({96'h0, MAX_Q}, {96'h0, ONE_Q}, 32'h0, 1'b1, MAX_Q, 1'b0);
    vecs[11] = mk('0, '0, MIN_Q, 1'b1, MIN_Q, 1'b0);

    // Reset state while rst is held
    repeat (2) tick();
    check_output("reset_in_ready", {31'h0, in_ready}, 32'h1);
    check_output("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check_output("reset_out", out, 32'h0);
    check_output("reset_sat", {31'h0, sat_flag}, 32'h0);
    rst = 1'b0;
    tick();

    // Table-driven transactions with the consumer always ready
    for (int i = 0; i < NV; i++) begin
      apply_stimulus(vecs[i], lat);
      check_output($sformatf("v%0d_latency", i), 32'(lat), 32'd5);
      check_output($sformatf("v%0d_out", i), out, vecs[i].exp_out);
      check_output($sformatf("v%0d_sat", i), {31'h0, sat_flag}, {31'h0, vecs[i].exp_sat});
      tick();
      check_output($sformatf("v%0d_release", i), {30'h0, out_valid, in_ready}, 32'h1);
    end

    // Backpressure: result must hold for 5 cycles while new input is offered
    out_ready = 1'b0;
    apply_stimulus(vecs[1], lat);
    check_output("bp_latency", 32'(lat), 32'd5);
    held = out;
    check_output("bp_out", held, vecs[1].exp_out);
    x_flat   = vecs[6].x;
    w_flat   = vecs[6].w;
    bias     = vecs[6].b;
    act_sel  = vecs[6].act;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_output($sformatf("bp_hold%0d", c), out, held);
      check_output($sformatf("bp_state%0d", c), {30'h0, out_valid, in_ready}, 32'h2);
    end
    out_ready = 1'b1;
    tick();
    check_output("bp_handshake", {30'h0, out_valid, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
    check_output("bp_accepted", {31'h0, in_ready}, 32'h0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_output("bp_next_latency", 32'(lat), 32'd5);
    check_output("bp_next_out", out, vecs[6].exp_out);
    tick();

    // Reset asserted in the middle of MAC aborts the transaction
    x_flat   = vecs[0].x;
    w_flat   = vecs[0].w;
    bias     = vecs[0].b;
    act_sel  = vecs[0].act;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_output("rst_mid_out", out, 32'h0);
    check_output("rst_mid_flags", {29'h0, out_valid, in_ready, sat_flag}, 32'h2);
    tick();
    rst = 1'b0;
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) lat++;
    end
    check_output("rst_no_partial", 32'(lat), 32'd0);
    apply_stimulus(vecs[6], lat);
    check_output("rst_after_latency", 32'(lat), 32'd5);
    check_output("rst_after_out", out, vecs[6].exp_out);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
